// File: rtl/seg_display_ctrl_if.sv
// Valid/ready handshake carrying a binary measurement into the display controller.
interface seg_display_ctrl_if #(
  parameter int unsigned BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             bin_valid;
  logic             bin_ready;

  modport master (output bin_in, output bin_valid, input bin_ready);
  modport slave  (input bin_in, input bin_valid, output bin_ready);
endinterface

// File: rtl/seg_display_ctrl.sv
// Binary-to-BCD display-update controller (shift-add-3 FSM) with overflow code
// and a free-running scan-rate enable tick.
module seg_display_ctrl #(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  seg_display_ctrl_if.slave   bin_if,
  output logic [3:0]          in1,
  output logic [3:0]          in2,
  output logic [3:0]          in3,
  output logic [3:0]          in4,
  output logic                overflow,
  output logic                done,
  output logic                scan_tick
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned      CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned      SCAN_W  = $clog2(SCAN_DIV);
  localparam logic [BIN_W-1:0] MAX_DEC = BIN_W'(9999);

  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_shift;
  logic [15:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [3:0]       r_in1, r_in2, r_in3, r_in4;
  logic             r_overflow;
  logic             r_done;
  logic [SCAN_W-1:0] r_scan_cnt;

  logic [15:0]      w_bcd_adj;
  logic [3:0]       w_nib;
  logic             w_scan_tick;

  // Add-3 correction on every nibble before the shift; the nibble MSB falls
  // out of the combined shift so no explicit inter-nibble carry is needed.
  always_comb begin
    w_bcd_adj = r_bcd;
    w_nib     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_nib = r_bcd[i*4 +: 4];
      if (w_nib >= 4'd5)
        w_bcd_adj[i*4 +: 4] = w_nib + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_in1      <= '0;
      r_in2      <= '0;
      r_in3      <= '0;
      r_in4      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bin_if.bin_valid) begin
            if (bin_if.bin_in > MAX_DEC) begin
              r_ovf   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_ovf   <= 1'b0;
              r_shift <= bin_if.bin_in;
              r_bcd   <= '0;
              r_cnt   <= '0;
              r_state <= CONV;
            end
          end
        end
        CONV: begin
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_cnt            <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1))
            r_state <= DONE;
        end
        DONE: begin
          if (r_ovf) begin
            r_in4 <= 4'hE;
            r_in3 <= 4'hE;
            r_in2 <= 4'hE;
            r_in1 <= 4'hE;
          end else begin
            r_in4 <= r_bcd[15:12];
            r_in3 <= r_bcd[11:8];
            r_in2 <= r_bcd[7:4];
            r_in1 <= r_bcd[3:0];
          end
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_scan_tick = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_scan_cnt <= '0;
    else if (w_scan_tick)
      r_scan_cnt <= '0;
    else
      r_scan_cnt <= r_scan_cnt + 1'b1;
  end

  assign bin_if.bin_ready = (r_state == IDLE);
  assign in1       = r_in1;
  assign in2       = r_in2;
  assign in3       = r_in3;
  assign in4       = r_in4;
  assign overflow  = r_overflow;
  assign done      = r_done;
  assign scan_tick = w_scan_tick;

endmodule
